// File: rtl/vend_credit_ctrl_pkg.sv
// Shared definitions for the vending credit controller: transaction state
// encoding, coin codes and coin values in cents.
package vend_credit_ctrl_pkg;

  // Transaction states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StCollect  = 2'd1,
    StDispense = 2'd2,
    StChange   = 2'd3
  } vend_state_e;

  // Coin codes as presented on coin_value.
  typedef enum logic [1:0] {
    CoinNickel  = 2'd0,
    CoinDime    = 2'd1,
    CoinQuarter = 2'd2,
    CoinSlug    = 2'd3
  } coin_code_e;

  localparam int unsigned NickelCents  = 5;
  localparam int unsigned DimeCents    = 10;
  localparam int unsigned QuarterCents = 25;

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity timer for the coin-collection phase.
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   clear   - synchronous clear (takes priority over enable)
//   enable  - count one cycle
//   expired - count has reached TIMEOUT-1
module vend_timeout_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] count_d, count_q;

  assign expired = (count_q == LastCount);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      // Holds at the last value; the owner leaves the counting state on expiry.
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending transaction controller: collects coins while the session is
// active, requests a dispense once credit reaches PRICE, then returns any
// remaining credit one nickel per cycle and pulses done.
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   active          - session active from the upstream session FSM
//   coin_valid      - one-cycle coin strobe, coin_value gives the coin code
//   cancel          - user cancel request
//   dispense_ready  - dispenser accepts the request
//   dispense_valid  - dispense request, held until handshake
//   change_pulse    - one nickel returned this cycle
//   coin_reject     - registered pulse: the strobed coin is returned
//   credit          - current credit in cents
//   busy            - controller not idle
//   done            - registered pulse at end of transaction
module vend_credit_ctrl
  import vend_credit_ctrl_pkg::*;
#(
  parameter int unsigned PRICE    = 15,
  parameter int unsigned CREDIT_W = 8,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                active,
  input  logic                coin_valid,
  input  logic [1:0]          coin_value,
  input  logic                cancel,
  input  logic                dispense_ready,
  output logic                dispense_valid,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                done
);

  localparam int unsigned SumW = CREDIT_W + 1;
  localparam logic [SumW-1:0]     MaxCredit = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [SumW-1:0]     PriceExt  = SumW'(PRICE);
  localparam logic [CREDIT_W-1:0] PriceW    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] NickelW   = CREDIT_W'(NickelCents);

  vend_state_e         state_d, state_q;
  logic [CREDIT_W-1:0] credit_d, credit_q;
  logic                coin_reject_d, coin_reject_q;
  logic                done_d, done_q;

  logic [SumW-1:0] coin_cents;
  logic [SumW-1:0] credit_sum;
  logic            coin_ok;
  logic            coin_accept;
  logic            credit_nz;
  logic            timer_clear;
  logic            timer_enable;
  logic            timer_expired;

  always_comb begin
    coin_cents = '0;
    unique case (coin_code_e'(coin_value))
      CoinNickel:  coin_cents = SumW'(NickelCents);
      CoinDime:    coin_cents = SumW'(DimeCents);
      CoinQuarter: coin_cents = SumW'(QuarterCents);
      CoinSlug:    coin_cents = '0;
    endcase
  end

  // One extra bit so an add that would overflow the register is detectable.
  assign credit_sum = {1'b0, credit_q} + coin_cents;
  assign coin_ok    = coin_valid && (coin_value != CoinSlug) && (credit_sum <= MaxCredit);
  assign credit_nz  = (credit_q != '0);

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    done_d       = 1'b0;
    coin_accept  = 1'b0;
    timer_clear  = 1'b1;
    timer_enable = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (active) state_d = StCollect;
      end

      StCollect: begin
        timer_clear = 1'b0;
        if (cancel || !active) begin
          timer_clear = 1'b1;
          if (credit_nz) begin
            state_d = StChange;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (timer_expired && credit_nz) begin
          state_d = StChange;
        end else if (coin_ok) begin
          coin_accept = 1'b1;
          timer_clear = 1'b1;
          credit_d    = credit_sum[CREDIT_W-1:0];
          if (credit_sum >= PriceExt) state_d = StDispense;
        end else begin
          // Idle time only counts once the customer has money in the machine.
          timer_enable = credit_nz;
        end
      end

      StDispense: begin
        if (dispense_ready) begin
          credit_d = credit_q - PriceW;
          state_d  = StChange;
        end
      end

      StChange: begin
        if (credit_nz) begin
          credit_d = credit_q - NickelW;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Every strobed coin that does not add to credit is handed back.
  assign coin_reject_d = coin_valid && !coin_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      credit_q      <= '0;
      coin_reject_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      coin_reject_q <= coin_reject_d;
      done_q        <= done_d;
    end
  end

  vend_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  assign dispense_valid = (state_q == StDispense);
  assign change_pulse   = (state_q == StChange) && credit_nz;
  assign busy           = (state_q != StIdle);
  assign credit         = credit_q;
  assign coin_reject    = coin_reject_q;
  assign done           = done_q;

endmodule

// File: tb/tb_vend_credit_ctrl.sv
module tb_vend_credit_ctrl;

  localparam int PRICE   = 15;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active = 1'b0, coin_valid = 1'b0, cancel = 1'b0, dispense_ready = 1'b0;
  logic [1:0] coin_value = 2'd0;
  logic       dispense_valid, change_pulse, coin_reject, busy, done;
  logic [7:0] credit;

  // Second instance with a narrow credit register to reach the saturation guard.
  logic       s_active = 1'b0, s_coin_valid = 1'b0, s_cancel = 1'b0, s_ready = 1'b0;
  logic [1:0] s_coin_value = 2'd0;
  logic       s_dispense_valid, s_change_pulse, s_coin_reject, s_busy, s_done;
  logic [4:0] s_credit;

  always #5 clk = ~clk;

  vend_credit_ctrl #(.PRICE(PRICE), .CREDIT_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .active(active), .coin_valid(coin_valid),
    .coin_value(coin_value), .cancel(cancel), .dispense_ready(dispense_ready),
    .dispense_valid(dispense_valid), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .credit(credit), .busy(busy), .done(done)
  );

  vend_credit_ctrl #(.PRICE(30), .CREDIT_W(5), .TIMEOUT(TIMEOUT)) dut_sat (
    .clk(clk), .rst(rst), .active(s_active), .coin_valid(s_coin_valid),
    .coin_value(s_coin_value), .cancel(s_cancel), .dispense_ready(s_ready),
    .dispense_valid(s_dispense_valid), .change_pulse(s_change_pulse),
    .coin_reject(s_coin_reject), .credit(s_credit), .busy(s_busy), .done(s_done)
  );

  int n_checks = 0, n_errors = 0;
  int n_rej, n_chg, n_dv, n_done;
  int tick_count = 0, first_chg_tick, last_coin_tick;
  int txn_codes[$], txn_gaps[$], obs_credit[$], exp_credit[$];
  int exp_rej, exp_change, exp_dv;
  bit exp_disp;

  // Advance one cycle and tally the output pulses seen after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    tick_count++;
    if (coin_reject) n_rej++;
    if (change_pulse) begin
      n_chg++;
      if (first_chg_tick < 0) first_chg_tick = tick_count;
    end
    if (dispense_valid) n_dv++;
    if (done) n_done++;
  endtask

  // Drive one transaction from txn_codes/txn_gaps and record what happens.
  task automatic run_txn(input bit with_cancel, input bit cancel_coin,
                         input int ready_delay, input bit stray);
    n_rej = 0; n_chg = 0; n_dv = 0; n_done = 0;
    first_chg_tick = -1;
    obs_credit.delete();
    active = 1'b1;
    tick();
    for (int i = 0; i < txn_codes.size(); i++) begin
      for (int g = 0; g < txn_gaps[i]; g++) tick();
      coin_valid = 1'b1;
      coin_value = 2'(txn_codes[i]);
      tick();
      coin_valid = 1'b0;
      last_coin_tick = tick_count;
      obs_credit.push_back(int'(credit));
      if (dispense_valid) break;
    end
    if (dispense_valid) begin
      for (int d = 0; d < ready_delay; d++) begin
        if (stray && d == 0) begin
          coin_valid = 1'b1;
          coin_value = 2'($urandom_range(0, 3));
          cancel = 1'b1;
          active = 1'b0;
        end
        tick();
        coin_valid = 1'b0;
        cancel = 1'b0;
        active = 1'b1;
      end
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
    end else if (with_cancel) begin
      cancel = 1'b1;
      coin_valid = cancel_coin;
      coin_value = 2'd0;
      tick();
      cancel = 1'b0;
      coin_valid = 1'b0;
    end
    for (int w = 0; w < 60 && n_done == 0; w++) tick();
    active = 1'b0;
    tick();
  endtask

  // Transaction-level reference: credit after each coin, dispense, change count.
  function automatic void model_txn(input bit cancel_coin, input int ready_delay,
                                    input bit stray);
    int cents[4] = '{5, 10, 25, 0};
    int c = 0;
    exp_credit.delete();
    exp_rej = 0;
    exp_disp = 1'b0;
    foreach (txn_codes[i]) begin
      if (exp_disp) break;
      if (txn_codes[i] == 3) exp_rej++;
      else c += cents[txn_codes[i]];
      exp_credit.push_back(c);
      if (c >= PRICE) exp_disp = 1'b1;
    end
    if (exp_disp) begin
      exp_change = (c - PRICE) / 5;
      exp_dv = ready_delay + 1;
      if (stray && ready_delay > 0) exp_rej++;
    end else begin
      exp_change = c / 5;
      exp_dv = 0;
      if (cancel_coin) exp_rej++;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_checks++;
    if ({dispense_valid, change_pulse, coin_reject, busy, done} !== 5'b0 || credit !== 8'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b/%0d required 00000/0",
               {dispense_valid, change_pulse, coin_reject, busy, done}, credit);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dime_nickel();
    txn_codes = '{1, 0}; txn_gaps = '{0, 0};
    run_txn(1'b0, 1'b0, 3, 1'b0);
    n_checks++;
    if (obs_credit.size() != 2 || obs_credit[0] != 10 || obs_credit[1] != 15) begin
      n_errors++;
      $display("FAIL dn_credit: got %p required '{10,15}", obs_credit);
    end
    n_checks++;
    if (n_dv != 4) begin n_errors++; $display("FAIL dn_valid_cycles: got %0d required 4", n_dv); end
    n_checks++;
    if (n_chg != 0 || n_done != 1) begin
      n_errors++; $display("FAIL dn_change_done: got %0d/%0d required 0/1", n_chg, n_done);
    end
    n_checks++;
    if (credit !== 8'd0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL dn_end: got credit %0d busy %b required 0/0", credit, busy);
    end
  endtask

  task automatic test_quarter();
    txn_codes = '{2}; txn_gaps = '{0};
    run_txn(1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (obs_credit.size() != 1 || obs_credit[0] != 25) begin
      n_errors++; $display("FAIL q_credit: got %p required '{25}", obs_credit);
    end
    n_checks++;
    if (n_dv != 1 || n_chg != 2 || n_done != 1) begin
      n_errors++;
      $display("FAIL q_counts: got dv %0d chg %0d done %0d required 1/2/1", n_dv, n_chg, n_done);
    end
  endtask

  task automatic test_cancel();
    txn_codes = '{1}; txn_gaps = '{1};
    run_txn(1'b1, 1'b1, 0, 1'b0);
    n_checks++;
    if (n_rej != 1 || n_chg != 2 || n_dv != 0 || n_done != 1) begin
      n_errors++;
      $display("FAIL cancel_counts: got rej %0d chg %0d dv %0d done %0d required 1/2/0/1",
               n_rej, n_chg, n_dv, n_done);
    end
  endtask

  task automatic test_rejects();
    active = 1'b0; coin_valid = 1'b1; coin_value = 2'd1;
    tick();
    coin_valid = 1'b0;
    n_checks++;
    if (coin_reject !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_reject: got rej %b credit %0d busy %b required 1/0/0",
               coin_reject, credit, busy);
    end
    tick();
    n_checks++;
    if (coin_reject !== 1'b0) begin
      n_errors++; $display("FAIL reject_pulse_width: got %b required 0", coin_reject);
    end
    txn_codes = '{3}; txn_gaps = '{0};
    run_txn(1'b1, 1'b0, 0, 1'b0);
    n_checks++;
    if (n_rej != 1 || obs_credit[0] != 0 || n_chg != 0 || n_done != 1) begin
      n_errors++;
      $display("FAIL slug: got rej %0d credit %0d chg %0d done %0d required 1/0/0/1",
               n_rej, obs_credit[0], n_chg, n_done);
    end
  endtask

  task automatic test_timeout();
    txn_codes = '{1}; txn_gaps = '{0};
    run_txn(1'b0, 1'b0, 0, 1'b0);
    n_checks++;
    if (first_chg_tick - last_coin_tick != TIMEOUT) begin
      n_errors++;
      $display("FAIL timeout_latency: got %0d required %0d",
               first_chg_tick - last_coin_tick, TIMEOUT);
    end
    n_checks++;
    if (n_chg != 2 || n_done != 1 || n_dv != 0) begin
      n_errors++;
      $display("FAIL timeout_counts: got chg %0d done %0d dv %0d required 2/1/0",
               n_chg, n_done, n_dv);
    end
  endtask

  task automatic test_async_reset();
    active = 1'b1;
    tick();
    coin_valid = 1'b1; coin_value = 2'd2;
    tick();
    coin_valid = 1'b0;
    n_checks++;
    if (dispense_valid !== 1'b1 || credit !== 8'd25) begin
      n_errors++; $display("FAIL ar_pre: got dv %b credit %0d required 1/25", dispense_valid, credit);
    end
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if (dispense_valid !== 1'b0 || busy !== 1'b0 || credit !== 8'd0) begin
      n_errors++;
      $display("FAIL ar_immediate: got dv %b busy %b credit %0d required 0/0/0",
               dispense_valid, busy, credit);
    end
    #2;
    rst = 1'b0;
    active = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0 || dispense_valid !== 1'b0 || credit !== 8'd0) begin
      n_errors++; $display("FAIL ar_after: got busy %b dv %b required 0/0", busy, dispense_valid);
    end
  endtask

  task automatic test_saturation();
    s_active = 1'b1;
    @(posedge clk); #1;
    s_coin_valid = 1'b1; s_coin_value = 2'd2;
    @(posedge clk); #1;
    n_checks++;
    if (s_credit !== 5'd25) begin n_errors++; $display("FAIL sat_q: got %0d required 25", s_credit); end
    s_coin_value = 2'd1;
    @(posedge clk); #1;
    n_checks++;
    if (s_coin_reject !== 1'b1 || s_credit !== 5'd25) begin
      n_errors++;
      $display("FAIL sat_guard: got rej %b credit %0d required 1/25", s_coin_reject, s_credit);
    end
    s_coin_value = 2'd0;
    @(posedge clk); #1;
    s_coin_valid = 1'b0;
    n_checks++;
    if (s_coin_reject !== 1'b0 || s_credit !== 5'd30 || s_dispense_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_edge: got rej %b credit %0d dv %b required 0/30/1",
               s_coin_reject, s_credit, s_dispense_valid);
    end
    s_ready = 1'b1;
    @(posedge clk); #1;
    s_ready = 1'b0; s_active = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (s_done !== 1'b1 || s_credit !== 5'd0 || s_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_done: got done %b credit %0d busy %b required 1/0/0",
               s_done, s_credit, s_busy);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      int len = $urandom_range(1, 6);
      bit cc = 1'($urandom_range(0, 1));
      int rd = $urandom_range(0, 4);
      bit st = 1'($urandom_range(0, 1));
      txn_codes.delete(); txn_gaps.delete();
      for (int i = 0; i < len; i++) begin
        txn_codes.push_back($urandom_range(0, 3));
        txn_gaps.push_back($urandom_range(0, 1));
      end
      model_txn(cc, rd, st);
      run_txn(1'b1, cc, rd, st);
      n_checks++;
      if (obs_credit != exp_credit) begin
        n_errors++; $display("FAIL rnd%0d_credit: got %p required %p", t, obs_credit, exp_credit);
      end
      n_checks++;
      if (n_rej != exp_rej || n_chg != exp_change || n_dv != exp_dv || n_done != 1) begin
        n_errors++;
        $display("FAIL rnd%0d_counts: got rej %0d chg %0d dv %0d done %0d required %0d/%0d/%0d/1",
                 t, n_rej, n_chg, n_dv, n_done, exp_rej, exp_change, exp_dv);
      end
      n_checks++;
      if (credit !== 8'd0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL rnd%0d_end: got credit %0d busy %b required 0/0", t, credit, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dime_nickel();
    test_quarter();
    test_cancel();
    test_rejects();
    test_timeout();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
